// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : one-cycle fetch request (fetch -> memory)
//   imem_addr  : word-aligned fetch address (fetch -> memory)
//   imem_valid : response strobe, one per request (memory -> fetch)
//   imem_rdata : instruction word, valid with imem_valid (memory -> fetch)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch outstanding,
// buffers a response that lands while decode is stalled, applies redirects
// (discarding a stale in-flight fetch) and drives the IF/ID register.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem             : instruction-memory bus (master side)
//   stall            : hold IF/ID, do not advance
//   redirect         : taken branch/jump, refetch from redirect_pc
//   redirect_pc      : redirect target (low two bits ignored)
//   if_id_valid/instr/pc4 : IF/ID register
//   op, funct        : opcode/function fields of IF/ID, zero when invalid
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_stage_if.master imem,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         if_id_valid,
  output logic [31:0]  if_id_instr,
  output logic [31:0]  if_id_pc4,
  output logic [5:0]   op,
  output logic [5:0]   funct
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        drop_q, drop_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;

  logic [31:0] redirect_tgt_s;
  logic [31:0] pc_plus4_s;

  assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4_s     = pc_q + 32'd4;

  // Next-state and datapath decisions for the fetch FSM and IF/ID register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_instr_d   = buf_instr_q;
    drop_d        = drop_q;
    // With no delivery, a stall freezes IF/ID; otherwise it goes empty
    // while instr/pc4 keep their stale contents.
    if_id_valid_d = stall ? if_id_valid_q : 1'b0;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        if (redirect) begin
          // The request just issued is still in flight; its answer is stale.
          pc_d          = redirect_tgt_s;
          drop_d        = 1'b1;
          if_id_valid_d = 1'b0;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d          = redirect_tgt_s;
          if_id_valid_d = 1'b0;
          if (imem.imem_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            // Refetch only after the stale response has come back.
            drop_d = 1'b1;
          end
        end else if (imem.imem_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem.imem_rdata;
            if_id_pc4_d   = pc_plus4_s;
            pc_d          = pc_plus4_s;
            state_d       = ST_REQ;
          end else begin
            buf_instr_d = imem.imem_rdata;
            state_d     = ST_FULL;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FULL: begin
        if (redirect) begin
          // Leaving FULL is what invalidates the holding buffer.
          pc_d          = redirect_tgt_s;
          if_id_valid_d = 1'b0;
          state_d       = ST_REQ;
        end else if (!stall) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = buf_instr_q;
          if_id_pc4_d   = pc_plus4_s;
          pc_d          = pc_plus4_s;
          state_d       = ST_REQ;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC, buffer and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      buf_instr_q   <= 32'h0000_0000;
      drop_q        <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0000_0000;
      if_id_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_instr_q   <= buf_instr_d;
      drop_q        <= drop_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = pc_q;

  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign op          = if_id_valid_q ? if_id_instr_q[31:26] : 6'b00_0000;
  assign funct       = if_id_valid_q ? if_id_instr_q[5:0]   : 6'b00_0000;

endmodule
